pc_gen: RTL

- PC generation stage, directly upstream of the fetch/predecode stage (ifu).
- Holds the architectural fetch PC and drives the instruction-memory request handshake.
- Selects the next PC from four sources: EX-stage redirect (flush), ifu static prediction, hold (stall / memory wait), and sequential PC+4.
- Its PC output feeds ifu's pc_i; ifu's prdt_taken_o / prdt_target_address_o loop back into it.

---
 rtl/pc_gen_pkg.sv | 17 +
 rtl/pc_gen.sv | 91 +++++++++
 2 files changed

// File: rtl/pc_gen_pkg.sv
// Shared fetch-side definitions for the PC generation stage.
//   INST_ADDR_BUS : instruction address bus width
//   RESET_PC_DEF  : PC fetched first after reset
//   pc_state_e    : PC generator FSM state encoding
package pc_gen_pkg;

   localparam int INST_ADDR_BUS = 32;

   localparam logic [INST_ADDR_BUS-1:0] RESET_PC_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      PC_IDLE  = 2'd0,
      PC_FETCH = 2'd1,
      PC_WAIT  = 2'd2
   } pc_state_e;

endpackage : pc_gen_pkg

// File: rtl/pc_gen.sv
// PC generation stage: holds the fetch PC and drives the instruction-memory
// request handshake, selecting the next PC from redirect, prediction, hold
// or sequential sources.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   stall_i         : hold PC and request
//   flush_i         : redirect from EX (highest priority), target flush_target_i
//   prdt_taken_i    : ifu predicts taken, target prdt_target_i
//   inst_ack_i      : instruction memory accepted request this cycle
//   inst_req_o      : fetch request to instruction memory
//   pc_o            : current fetch PC / memory address
//   pc_valid_o      : pc_o/instruction pair valid for ifu this cycle
//   misalign_o      : pulse after a redirect target with nonzero low bits
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int                 ADDR_W   = INST_ADDR_BUS,
   parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic [ADDR_W-1:0] flush_target_i,
   input  logic              prdt_taken_i,
   input  logic [ADDR_W-1:0] prdt_target_i,
   input  logic              inst_ack_i,
   output logic              inst_req_o,
   output logic [ADDR_W-1:0] pc_o,
   output logic              pc_valid_o,
   output logic              misalign_o
);

   pc_state_e         state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              inst_req_q, inst_req_d;
   logic              misalign_q, misalign_d;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      misalign_d = 1'b0;
      case (state_q)
         PC_IDLE: begin
            // pc stays at RESET_PC so the first request goes out one cycle
            // after reset release
            state_d = PC_FETCH;
         end
         default: begin
            if (flush_i) begin
               // redirect beats stall and wait; any ack this cycle is dropped
               pc_d       = {flush_target_i[ADDR_W-1:2], 2'b00};
               misalign_d = |flush_target_i[1:0];
               state_d    = PC_FETCH;
            end else if (stall_i) begin
               state_d = state_q;
            end else if (!inst_ack_i) begin
               state_d = PC_WAIT;
            end else if (prdt_taken_i) begin
               pc_d       = {prdt_target_i[ADDR_W-1:2], 2'b00};
               misalign_d = |prdt_target_i[1:0];
               state_d    = PC_FETCH;
            end else begin
               pc_d    = pc_q + ADDR_W'(4);
               state_d = PC_FETCH;
            end
         end
      endcase
      inst_req_d = (state_d != PC_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= PC_IDLE;
         pc_q       <= RESET_PC;
         inst_req_q <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         inst_req_q <= inst_req_d;
         misalign_q <= misalign_d;
      end
   end

   assign inst_req_o = inst_req_q;
   assign pc_o       = pc_q;
   assign misalign_o = misalign_q;
   assign pc_valid_o = inst_req_q & inst_ack_i & ~flush_i;

endmodule : pc_gen
